// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared constants and types for the BCD conversion blocks. The display-side
// converter (binary -> BCD) and the entry-side converter (BCD -> binary) both
// import this package.
//
// Contents:
//   DIGIT_W         width of one BCD digit
//   MAX_DIGIT       largest legal decimal digit value
//   ADJ_THRESH      reverse double-dabble: digits at or above this get adjusted
//   ADJ_SUB         amount subtracted from a digit that needs adjusting
//   DEF_NUM_DIGITS  default digit count of the converters
//   DEF_BIN_W       default binary width of the converters
//   state_t         converter FSM encoding (IDLE / CONVERT / DONE)
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int         DIGIT_W        = 4;
    localparam logic [3:0] MAX_DIGIT      = 4'd9;
    localparam logic [3:0] ADJ_THRESH     = 4'd8;
    localparam logic [3:0] ADJ_SUB        = 4'd3;

    localparam int         DEF_NUM_DIGITS = 10;
    localparam int         DEF_BIN_W      = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Per-digit correction step of reverse double-dabble. After the work register
// has been shifted right by one bit, a digit that picked up the weight-8 bit
// from its upper neighbour (value 10 in the digit above becomes 5 here, i.e.
// +8 instead of +5) is pulled back by 3.
//
// Ports:
//   d   in   4  shifted digit
//   q   out  4  corrected digit (d - 3 when d >= 8, else d)
//
// Inputs 8..15 map to 5..12, so the subtraction never underflows.
// -----------------------------------------------------------------------------
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_comb begin
        q = d;
        if (d >= ADJ_THRESH) begin
            q = d - ADJ_SUB;
        end
    end

endmodule : bcd_digit_adjust

// File: rtl/bcd_to_binary.sv
// -----------------------------------------------------------------------------
// bcd_to_binary
// Sequential BCD-to-binary converter using reverse double-dabble, one result
// bit per clock. Takes NUM_DIGITS packed decimal digits from the digit-entry
// front end and hands an unsigned BIN_W-bit value to the operand path.
//
// Ports:
//   clk        in   1              system clock, rising edge
//   rst_n      in   1              asynchronous active-low reset
//   in_valid   in   1              bcd_in valid
//   in_ready   out  1              converter can accept (IDLE only)
//   bcd_in     in   4*NUM_DIGITS   packed digits, bcd_in[3:0] = units
//   out_valid  out  1              result valid, held until accepted
//   out_ready  in   1              consumer accepts result
//   bin_out    out  BIN_W          converted value
//   err_digit  out  1              an input digit was > 9; bin_out is 0
//   overflow   out  1              value >= 2^BIN_W; bin_out = value mod 2^BIN_W
//   state_dbg  out  2              current FSM state (state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload stable while valid is high and
// not yet accepted; ready may depend on state only. in_ready is high only in
// IDLE and out_valid only in DONE, so an input is never taken in the same
// cycle a result is handed off.
//
// Latency: a legal input accepted at edge E0 shows out_valid after edge
// E(BIN_W); an input with a bad digit shows out_valid after E0+1.
// -----------------------------------------------------------------------------
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int BIN_W      = DEF_BIN_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BIN_W-1:0]              bin_out,
    output logic                          err_digit,
    output logic                          overflow,
    output logic [1:0]                    state_dbg
);

    localparam int               BCD_W     = DIGIT_W * NUM_DIGITS;
    localparam int               CNT_W     = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BIN_W-1:0]   bin_reg;

    logic               accept;
    logic               digit_bad;
    logic               last_iter;
    logic [BCD_W-1:0]   sh_bcd;
    logic [BIN_W-1:0]   sh_bin;
    logic [BCD_W-1:0]   adj_bcd;

    // ---------------------------------------------------------------------
    // Input digit screening
    // ---------------------------------------------------------------------
    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_in[i*DIGIT_W +: DIGIT_W] > MAX_DIGIT) begin
                digit_bad = 1'b1;
            end
        end
    end

    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt == LAST_ITER);

    // ---------------------------------------------------------------------
    // One reverse double-dabble step: shift {bcd_reg, bin_reg} right by one,
    // then correct every digit of the shifted BCD part.
    // ---------------------------------------------------------------------
    assign sh_bcd = {1'b0, bcd_reg[BCD_W-1:1]};
    assign sh_bin = {bcd_reg[0], bin_reg[BIN_W-1:1]};

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .d (sh_bcd [g*DIGIT_W +: DIGIT_W]),
            .q (adj_bcd[g*DIGIT_W +: DIGIT_W])
        );
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = digit_bad ? DONE : CONVERT;
                end
            end
            CONVERT: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state;

    // ---------------------------------------------------------------------
    // Datapath: work register, iteration counter, result capture.
    // Result registers are only written when a conversion ends, so they
    // keep the last result after handoff.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_reg   <= '0;
            bin_reg   <= '0;
            cnt       <= '0;
            bin_out   <= '0;
            err_digit <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (digit_bad) begin
                            bin_out   <= '0;
                            err_digit <= 1'b1;
                            overflow  <= 1'b0;
                        end else begin
                            bcd_reg <= bcd_in;
                            bin_reg <= '0;
                            cnt     <= '0;
                        end
                    end
                end
                CONVERT: begin
                    bcd_reg <= adj_bcd;
                    bin_reg <= sh_bin;
                    cnt     <= cnt + 1'b1;
                    if (last_iter) begin
                        // Whatever is left in the BCD part after BIN_W shifts
                        // is floor(value / 2^BIN_W); non-zero means it didn't fit.
                        bin_out   <= sh_bin;
                        overflow  <= |adj_bcd;
                        err_digit <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : bcd_to_binary

// File: tb/tb_bcd_to_binary.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_binary
// Directed bench for bcd_to_binary with a decimal-arithmetic reference model,
// an expected-result queue checked every cycle out_valid is high, and
// hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_bcd_to_binary;

    localparam int ND = 10;
    localparam int BW = 32;
    localparam int IW = 4 * ND;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [IW-1:0] bcd_in    = '0;
    logic          in_ready;
    logic          out_valid;
    logic [BW-1:0] bin_out;
    logic          err_digit;
    logic          overflow;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_to_binary #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err_digit (err_digit),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // ---------------------------------------------------------------------
    // Scoreboard state: {err, ovf, bin} per accepted input + accept cycle
    // ---------------------------------------------------------------------
    logic [BW+1:0] exp_q[$];
    int            acc_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: evaluate the decimal number directly.
    function automatic logic [BW+1:0] model(input logic [IW-1:0] b);
        longint unsigned v   = 0;
        logic            err = 1'b0;
        logic [3:0]      d;
        logic [BW-1:0]   lo;
        for (int i = ND - 1; i >= 0; i--) begin
            d = b[i*4 +: 4];
            if (d > 4'd9) err = 1'b1;
            v = v * 10 + longint'(d);
        end
        if (err) return {1'b1, 1'b0, {BW{1'b0}}};
        lo = v[BW-1:0];
        return {1'b0, (v >= (64'd1 << BW)), lo};
    endfunction

    // ---------------------------------------------------------------------
    // Compare process
    // ---------------------------------------------------------------------
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    check("bin_out",   64'(bin_out),   64'(exp_q[0][BW-1:0]));
                    check("overflow",  64'(overflow),  64'(exp_q[0][BW]));
                    check("err_digit", 64'(err_digit), 64'(exp_q[0][BW+1]));
                    check("in_ready_in_done", 64'(in_ready), 64'd0);
                    if (!prev_ov)
                        check("latency", 64'(cyc - acc_q[0]), exp_q[0][BW+1] ? 64'd1 : 64'(BW + 1));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            prev_ov = out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic send(input logic [IW-1:0] b, input bit hold);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 300);
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1;
        bcd_in   = b;
        exp_q.push_back(model(b));
        acc_q.push_back(cyc);
        @(posedge clk);
        #1 in_valid = hold;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            acc_q.delete();
        end
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    logic [IW-1:0] b2b_vals[4];
    int            prev_acc;
    int            t;

    initial begin
        // Model pinned to hand-computed values.
        check("model_12345",  64'(model(40'h0000012345)), 64'({2'b00, 32'h00003039}));
        check("model_max",    64'(model(40'h9999999999)), 64'({2'b01, 32'h540BE3FF}));
        check("model_baddig", 64'(model(40'h000000A123)), 64'({2'b10, 32'h0}));

        // Reset state
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_bin_out",   64'(bin_out),   64'd0);
        check("rst_err",       64'(err_digit), 64'd0);
        check("rst_ovf",       64'(overflow),  64'd0);
        rst_n = 1'b1;

        // Basic conversions and the 2^32 boundary
        send(40'h0000012345, 1'b0); drain();
        check("lit_12345", 64'(bin_out), 64'h3039);
        send(40'h4294967295, 1'b0); drain();
        check("lit_2p32m1", 64'({overflow, bin_out}), 64'h0_FFFFFFFF);
        send(40'h4294967296, 1'b0); drain();
        check("lit_2p32", 64'({overflow, bin_out}), 64'h1_00000000);
        send(40'h9999999999, 1'b0); drain();
        check("lit_max", 64'({overflow, bin_out}), 64'h1_540BE3FF);

        // Bad digit in position 3
        send(40'h000000A123, 1'b0); drain();
        check("lit_baddig", 64'({err_digit, overflow, bin_out}), 64'h2_00000000);

        // Consumer stall with ignored input pulses
        out_ready = 1'b0;
        send(40'h0000000010, 1'b0);
        t = 0;
        while (!out_valid && t < 100) begin @(negedge clk); t++; end
        check("stall_reach_done", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            in_valid = i[0];
            bcd_in   = 40'h0000000077;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("lit_10", 64'(bin_out), 64'd10);
        repeat (40) @(negedge clk);
        check("idle_after_stall", 64'(in_ready), 64'd1);

        // Asynchronous reset mid-conversion
        send(40'h0000012345, 1'b0);
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd1);
        check("arst_bin_out",   64'(bin_out),   64'd0);
        check("arst_flags",     64'({err_digit, overflow}), 64'd0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(40'h0000000000, 1'b0); drain();
        check("lit_zero", 64'({err_digit, overflow, bin_out}), 64'd0);

        // Back-to-back with in_valid held high
        b2b_vals[0] = 40'h0000000001;
        b2b_vals[1] = 40'h0000065535;
        b2b_vals[2] = 40'h0123456789;
        b2b_vals[3] = 40'h5000000000;
        prev_acc = -1;
        for (int k = 0; k < 4; k++) begin
            send(b2b_vals[k], k != 3);
            if (prev_acc >= 0) check("b2b_interval", 64'(acc_q[$] - prev_acc), 64'd34);
            prev_acc = acc_q[$];
        end
        drain();
        check("lit_5e9", 64'({overflow, bin_out}), 64'h1_2A05F200);
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_bcd_to_binary

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
Sequential BCD-to-binary converter; the inverse of the ALU-output display path (sev_seg_disp). It accepts a packed vector of decimal digits and produces the unsigned binary value using reverse double-dabble (shift-right / subtract-3), one bit per clock. It flags non-decimal digits and results that do not fit in BIN_W bits. Sits between a digit-entry front end (keypad/switch digits) and the register-file/ALU operand path.

Parameters:
NUM_DIGITS, 10, number of BCD digits accepted; digit 0 is least significant
BIN_W, 32, width of binary result; also the number of conversion iterations

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  bcd_in valid
in_ready  output  1  converter can accept; high only in IDLE
bcd_in  input  4*NUM_DIGITS  packed digits; bcd_in[3:0] = units digit
out_valid  output  1  result valid; held until accepted
out_ready  input  1  consumer accepts result
bin_out  output  BIN_W  converted value
err_digit  output  1  some input digit > 9; bin_out forced 0
overflow  output  1  decimal value >= 2^BIN_W; bin_out = value mod 2^BIN_W

Behaviour:
- Reset (async assert, sync-released by system): state=IDLE, in_ready=1, out_valid=0, bin_out=0, err_digit=0, overflow=0, iteration counter=0, work register=0. Reset asserted mid-conversion or during DONE aborts immediately; no result is produced.
- Work register: {bcd_reg[4*NUM_DIGITS-1:0], bin_reg[BIN_W-1:0]}.
- States: IDLE, CONVERT, DONE.
- IDLE: in_ready=1. Accept on in_valid && in_ready at edge E0. If any digit > 9: go DONE, err_digit=1, overflow=0, bin_out=0; out_valid visible after E0 (1-cycle latency). Otherwise load bcd_reg=bcd_in, bin_reg=0, counter=0, go CONVERT.
- CONVERT: each edge: shift the whole work register right by 1 (bcd_reg LSB into bin_reg MSB, 0 into bcd_reg MSB), then for every digit of the shifted bcd_reg, if digit >= 8 subtract 3. counter increments; after BIN_W iterations (edges E1..E32 for BIN_W=32) go DONE. At that edge bin_out=bin_reg after final shift, overflow = (post-shift bcd_reg != 0), err_digit=0. out_valid visible after E32: latency BIN_W+1 edges from acceptance to out_valid high. in_ready=0; in_valid ignored.
- DONE: out_valid=1; bin_out/err_digit/overflow stable while out_valid && !out_ready. On out_valid && out_ready: go IDLE, out_valid=0 next cycle; outputs retain last values. No bypass: new input is not accepted in the same cycle as result handoff (in_ready is low in DONE).
- Arithmetic: digit adjust is 4-bit unsigned, inputs 8..15 map to 5..12 (never underflows). All values unsigned; no sign handling.
- Throughput: one conversion per BIN_W+2 cycles minimum.

Decomposition:
- Shared package bcd_pkg: DIGIT_W=4, MAX_DIGIT=9, ADJ_THRESH=8, ADJ_SUB=3, state encoding (IDLE/CONVERT/DONE), default NUM_DIGITS/BIN_W. Reused by the display-side converter.
- Sub-module bcd_digit_adjust: combinational, 4-bit in/out, subtract 3 when >= 8. Instantiated NUM_DIGITS times via generate.
- Top: FSM, counter, work register, handshake, error/overflow capture.

Test Plan:
- bcd_in = digits 0000012345, in_valid pulse, out_ready=1 -> out_valid 33 cycles after acceptance, bin_out=32'h00003039, err_digit=0, overflow=0.
- bcd_in = 4294967295 -> bin_out=32'hFFFFFFFF, overflow=0; then 4294967296 -> bin_out=32'h00000000, overflow=1; 9999999999 -> overflow=1, bin_out=32'h540BE3FF.
- bcd_in with digit 3 = 4'hA -> out_valid one cycle after acceptance, err_digit=1, bin_out=0, no CONVERT cycles.
- out_ready held 0 for 10 cycles after out_valid -> out_valid, bin_out, flags stable; in_ready stays 0; in_valid pulses ignored; result for 0000000010 = 32'd10 handed off on first out_ready.
- rst_n pulsed low at iteration 15 of a conversion -> all outputs reset values immediately (asynchronously); in_ready=1 after release; next conversion of 0000000000 yields 0 with correct latency.
- Back-to-back: in_valid held high with out_ready=1 -> one acceptance per 34 cycles; each bin_out matches its input.
